cache_line_store: RTL and testbench

Direct-mapped, write-through data cache array and miss controller that consumes the tag/index fields produced by the cache address decoder. Holds 2^INDEX_WIDTH one-word lines with tag and valid state, serves load hits in the same cycle, and runs a stall/refill handshake to main memory on load misses and on every store. Sits between the memory-stage decode and the data memory port.

---
 rtl/cache_line_store.sv | 164 ++++++++++++++++
 tb/tb_cache_line_store.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cache_line_store.sv
// Direct-mapped write-through cache array with a miss/store handshake to memory.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_line_store #(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 26,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TAG_WIDTH-1:0]   iTag,
  input  logic [INDEX_WIDTH-1:0] iIndex,
  input  logic                   iRead,
  input  logic                   iWrite,
  input  logic [DATA_WIDTH-1:0]  iWriteData,
  input  logic                   iFlush,
  input  logic [INDEX_WIDTH-1:0] iIndexFlush,
  output logic [DATA_WIDTH-1:0]  oData,
  output logic                   oStall,
  output logic                   oMemReq,
  output logic                   oMemWe,
  output logic [31:0]            oMemAddr,
  output logic [DATA_WIDTH-1:0]  oMemWData,
  input  logic                   iMemAck,
  input  logic [DATA_WIDTH-1:0]  iMemRData,
  output logic [31:0]            oHitCount,
  output logic [31:0]            oMissCount
);
  localparam int LINES = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_data [LINES];
  logic [TAG_WIDTH-1:0]    r_tag  [LINES];
  logic [LINES-1:0]        r_valid;
  logic [TAG_WIDTH-1:0]    r_reqTag;
  logic [INDEX_WIDTH-1:0]  r_reqIdx;
  logic [DATA_WIDTH-1:0]   r_fill;
  logic                    r_memReq;
  logic                    r_memWe;
  logic [31:0]             r_memAddr;
  logic [DATA_WIDTH-1:0]   r_memWData;

  logic w_hit;
  logic w_fillDone;
  logic w_stall;

  assign w_hit      = r_valid[iIndex] && (r_tag[iIndex] == iTag);
  assign w_fillDone = (r_state == S_FILL) && iMemAck;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_reqTag   <= '0;
      r_reqIdx   <= '0;
      r_fill     <= '0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWData <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (iWrite) begin
            r_reqTag   <= iTag;
            r_reqIdx   <= iIndex;
            r_memWData <= iWriteData;
            r_memAddr  <= {iTag, iIndex, 2'b00};
            r_memReq   <= 1'b1;
            r_memWe    <= 1'b1;
            r_state    <= S_WRITE;
          end else if (iRead && !w_hit) begin
            r_reqTag  <= iTag;
            r_reqIdx  <= iIndex;
            r_memAddr <= {iTag, iIndex, 2'b00};
            r_memReq  <= 1'b1;
            r_memWe   <= 1'b0;
            r_state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (iMemAck) begin
            r_memReq <= 1'b0;
            r_fill   <= iMemRData;
            r_state  <= S_RESP;
          end
        end
        S_WRITE: begin
          if (iMemAck) begin
            r_memReq <= 1'b0;
            r_state  <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Flush is applied after the fill so it wins when both hit the same line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (w_fillDone) r_valid[r_reqIdx] <= 1'b1;
      if (iFlush)     r_valid[iIndexFlush] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fillDone) begin
        r_data[r_reqIdx] <= iMemRData;
        r_tag[r_reqIdx]  <= r_reqTag;
      end else if (r_state == S_IDLE && iWrite && w_hit) begin
        r_data[iIndex] <= iWriteData;
      end
    end
  end

  always_comb begin
    w_stall = 1'b0;
    unique case (r_state)
      S_IDLE:          w_stall = iWrite || (iRead && !w_hit);
      S_FILL, S_WRITE: w_stall = 1'b1;
      S_RESP:          w_stall = 1'b0;
      default:         w_stall = 1'b0;
    endcase
  end

  assign oStall    = w_stall;
  assign oData     = (r_state == S_RESP) ? r_fill : r_data[iIndex];
  assign oMemReq   = r_memReq;
  assign oMemWe    = r_memWe;
  assign oMemAddr  = r_memAddr;
  assign oMemWData = r_memWData;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hitCount;
  logic [31:0] r_missCount;
  logic        w_lookup;

  assign w_lookup = (r_state == S_IDLE) && iRead && !iWrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hitCount  <= '0;
      r_missCount <= '0;
    end else begin
      if (w_lookup && w_hit && r_hitCount != '1)
        r_hitCount <= r_hitCount + 32'd1;
      if (w_lookup && !w_hit && r_missCount != '1)
        r_missCount <= r_missCount + 32'd1;
    end
  end

  assign oHitCount  = r_hitCount;
  assign oMissCount = r_missCount;
`else
  assign oHitCount  = '0;
  assign oMissCount = '0;
`endif

endmodule

// File: tb/tb_cache_line_store.sv
// Directed table-driven bench for cache_line_store, plus hand-written
// sequences for reset during a refill and the statistics counters.
module tb_cache_line_store;
  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] iTag;
  logic [3:0]  iIndex;
  logic        iRead, iWrite, iFlush, iMemAck;
  logic [31:0] iWriteData, iMemRData;
  logic [3:0]  iIndexFlush;
  logic [31:0] oData, oMemAddr, oMemWData, oHitCount, oMissCount;
  logic        oStall, oMemReq, oMemWe;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cache_line_store #(.DATA_WIDTH(32), .TAG_WIDTH(26), .INDEX_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .iTag(iTag), .iIndex(iIndex), .iRead(iRead),
    .iWrite(iWrite), .iWriteData(iWriteData), .iFlush(iFlush),
    .iIndexFlush(iIndexFlush), .oData(oData), .oStall(oStall),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemWData(oMemWData), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .oHitCount(oHitCount), .oMissCount(oMissCount)
  );

  // ctl = {rd, wr, flush, ack}; ex = {stall, memReq, memWe, checkData}
  typedef struct {
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [3:0]  ctl;
    logic [31:0] wdata;
    logic [3:0]  fidx;
    logic [31:0] rdata;
    logic [3:0]  ex;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt [39];

`ifdef CACHE_STATS_EN
  localparam logic [31:0] EXP_HITS   = 32'd4;
  localparam logic [31:0] EXP_MISSES = 32'd1;
`else
  localparam logic [31:0] EXP_HITS   = 32'd0;
  localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [25:0] t, input logic [3:0] x, input logic rd,
                       input logic wr, input logic [31:0] wd, input logic fl,
                       input logic [3:0] fx, input logic ak, input logic [31:0] rdv);
    @(negedge clk);
    iTag = t; iIndex = x; iRead = rd; iWrite = wr; iWriteData = wd;
    iFlush = fl; iIndexFlush = fx; iMemAck = ak; iMemRData = rdv;
    #2;
  endtask

  initial begin
    vt[0]  = '{26'h1, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b1000, 32'h0,   32'h0};
    vt[1]  = '{26'h1, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b1100, 32'h4C,  32'h0};
    vt[2]  = '{26'h1, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b1100, 32'h4C,  32'h0};
    vt[3]  = '{26'h1, 4'h3, 4'b1001, 32'h0,        4'h0, 32'hDEADBEEF, 4'b1100, 32'h4C,  32'h0};
    vt[4]  = '{26'h1, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'hDEADBEEF};
    vt[5]  = '{26'h1, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'hDEADBEEF};
    vt[6]  = '{26'h1, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'hDEADBEEF};
    vt[7]  = '{26'h1, 4'h3, 4'b0100, 32'h12345678, 4'h0, 32'h0,        4'b1000, 32'h0,   32'h0};
    vt[8]  = '{26'h1, 4'h3, 4'b0101, 32'h12345678, 4'h0, 32'h0,        4'b1110, 32'h4C,  32'h0};
    vt[9]  = '{26'h1, 4'h3, 4'b0100, 32'h12345678, 4'h0, 32'h0,        4'b0000, 32'h0,   32'h0};
    vt[10] = '{26'h1, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'h12345678};
    vt[11] = '{26'h2, 4'h5, 4'b0100, 32'hA5A5A5A5, 4'h0, 32'h0,        4'b1000, 32'h0,   32'h0};
    vt[12] = '{26'h2, 4'h5, 4'b0100, 32'hA5A5A5A5, 4'h0, 32'h0,        4'b1110, 32'h94,  32'h0};
    vt[13] = '{26'h2, 4'h5, 4'b0101, 32'hA5A5A5A5, 4'h0, 32'h0,        4'b1110, 32'h94,  32'h0};
    vt[14] = '{26'h2, 4'h5, 4'b0100, 32'hA5A5A5A5, 4'h0, 32'h0,        4'b0000, 32'h0,   32'h0};
    vt[15] = '{26'h2, 4'h5, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b1000, 32'h0,   32'h0};
    vt[16] = '{26'h2, 4'h5, 4'b1001, 32'h0,        4'h0, 32'h0BADF00D, 4'b1100, 32'h94,  32'h0};
    vt[17] = '{26'h2, 4'h5, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'h0BADF00D};
    vt[18] = '{26'h2, 4'h5, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'h0BADF00D};
    vt[19] = '{26'h3, 4'h7, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b1000, 32'h0,   32'h0};
    vt[20] = '{26'h3, 4'h7, 4'b1011, 32'h0,        4'h7, 32'hCAFEF00D, 4'b1100, 32'hDC,  32'h0};
    vt[21] = '{26'h3, 4'h7, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'hCAFEF00D};
    vt[22] = '{26'h3, 4'h7, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b1000, 32'h0,   32'h0};
    vt[23] = '{26'h3, 4'h7, 4'b1001, 32'h0,        4'h0, 32'h11112222, 4'b1100, 32'hDC,  32'h0};
    vt[24] = '{26'h3, 4'h7, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'h11112222};
    vt[25] = '{26'h3, 4'h7, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'h11112222};
    vt[26] = '{26'h3, 4'h7, 4'b1010, 32'h0,        4'h7, 32'h0,        4'b0001, 32'h0,   32'h11112222};
    vt[27] = '{26'h3, 4'h7, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b1000, 32'h0,   32'h0};
    vt[28] = '{26'h3, 4'h7, 4'b1001, 32'h0,        4'h0, 32'h33334444, 4'b1100, 32'hDC,  32'h0};
    vt[29] = '{26'h3, 4'h7, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'h33334444};
    vt[30] = '{26'h0, 4'h0, 4'b0001, 32'h0,        4'h0, 32'hFFFFFFFF, 4'b0000, 32'h0,   32'h0};
    vt[31] = '{26'h0, 4'h0, 4'b0000, 32'h0,        4'h0, 32'h0,        4'b0000, 32'h0,   32'h0};
    vt[32] = '{26'h1, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'h12345678};
    vt[33] = '{26'h9, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b1000, 32'h0,   32'h0};
    vt[34] = '{26'h9, 4'h3, 4'b1001, 32'h0,        4'h0, 32'h77778888, 4'b1100, 32'h24C, 32'h0};
    vt[35] = '{26'h9, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'h77778888};
    vt[36] = '{26'h1, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b1000, 32'h0,   32'h0};
    vt[37] = '{26'h1, 4'h3, 4'b1001, 32'h0,        4'h0, 32'h12345678, 4'b1100, 32'h4C,  32'h0};
    vt[38] = '{26'h1, 4'h3, 4'b1000, 32'h0,        4'h0, 32'h0,        4'b0001, 32'h0,   32'h12345678};

    rst = 1'b1; iTag = '0; iIndex = '0; iRead = 1'b0; iWrite = 1'b0;
    iWriteData = '0; iFlush = 1'b0; iIndexFlush = '0; iMemAck = 1'b0; iMemRData = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #2;
    chk("rst.stall", 32'(oStall), 32'd0);
    chk("rst.memReq", 32'(oMemReq), 32'd0);
    chk("rst.memWe", 32'(oMemWe), 32'd0);
    chk("rst.memAddr", oMemAddr, 32'h0);
    chk("rst.memWData", oMemWData, 32'h0);
    chk("rst.hits", oHitCount, 32'd0);
    chk("rst.misses", oMissCount, 32'd0);

    for (int i = 0; i < 39; i++) begin
      drive(vt[i].tag, vt[i].idx, vt[i].ctl[3], vt[i].ctl[2], vt[i].wdata,
            vt[i].ctl[1], vt[i].fidx, vt[i].ctl[0], vt[i].rdata);
      chk($sformatf("v%0d.stall", i), 32'(oStall), 32'(vt[i].ex[3]));
      chk($sformatf("v%0d.memReq", i), 32'(oMemReq), 32'(vt[i].ex[2]));
      if (vt[i].ex[2]) begin
        chk($sformatf("v%0d.memWe", i), 32'(oMemWe), 32'(vt[i].ex[1]));
        chk($sformatf("v%0d.memAddr", i), oMemAddr, vt[i].e_addr);
        if (vt[i].ex[1]) chk($sformatf("v%0d.memWData", i), oMemWData, vt[i].wdata);
      end
      if (vt[i].ex[0]) chk($sformatf("v%0d.data", i), oData, vt[i].e_data);
    end

    // Reset while a refill is outstanding, then a late acknowledge.
    drive(26'h2, 4'h5, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    chk("r.hit5.stall", 32'(oStall), 32'd0);
    chk("r.hit5.data", oData, 32'h0BADF00D);
    drive(26'h4, 4'h9, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    chk("r.miss9.stall", 32'(oStall), 32'd1);
    drive(26'h4, 4'h9, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    chk("r.fill9.memReq", 32'(oMemReq), 32'd1);
    chk("r.fill9.memAddr", oMemAddr, 32'h124);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(26'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 32'h55555555);
    chk("r.after.memReq", 32'(oMemReq), 32'd0);
    chk("r.after.stall", 32'(oStall), 32'd0);
    chk("r.after.memAddr", oMemAddr, 32'h0);
    chk("r.after.hits", oHitCount, 32'd0);
    chk("r.after.misses", oMissCount, 32'd0);
    drive(26'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    chk("r.lateack.memReq", 32'(oMemReq), 32'd0);
    drive(26'h2, 4'h5, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    chk("r.inval5.stall", 32'(oStall), 32'd1);
    drive(26'h2, 4'h5, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 32'h66667777);
    chk("r.refill5.memReq", 32'(oMemReq), 32'd1);
    chk("r.refill5.memAddr", oMemAddr, 32'h94);
    drive(26'h2, 4'h5, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    chk("r.resp5.stall", 32'(oStall), 32'd0);
    chk("r.resp5.data", oData, 32'h66667777);
    for (int k = 0; k < 4; k++) begin
      drive(26'h2, 4'h5, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
      chk($sformatf("r.hit%0d.stall", k), 32'(oStall), 32'd0);
      chk($sformatf("r.hit%0d.data", k), oData, 32'h66667777);
    end
    drive(26'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    chk("stats.hits", oHitCount, EXP_HITS);
    chk("stats.misses", oMissCount, EXP_MISSES);
    drive(26'h4, 4'h9, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    chk("r.line9.stall", 32'(oStall), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
